// File: rtl/pc_branch_unit.sv
// PC register and branch/jump resolution for the single-cycle core; taken/pc_plus4 are 0-cycle, new pc 1 cycle later.
// No handshake: stall freezes all state, HALT freezes PC/counters/bad_addr until resume.
module pc_branch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_PC  = 32'h0000_0100,
  parameter logic [31:0]      CNT_INIT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             branch_en,
  input  logic [2:0]       branch_op,
  input  logic             jump,
  input  logic             jalr,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero_flag,
  input  logic             sign_flag,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             taken,
  output logic             misalign_trap,
  output logic [WIDTH-1:0] bad_addr,
  output logic             halted,
  output logic [31:0]      retired_count,
  output logic [31:0]      taken_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] bad_addr_q;
  logic             misalign_q;
  logic [31:0]      retired_q, taken_cnt_q;

  logic             cond;
  logic             br_taken;
  logic             in_run;
  logic             taken_int;
  logic             trap;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] seq_pc;

  // Branch condition from the SUB flags; signed overflow deliberately not corrected.
  always_comb begin
    cond = 1'b0;
    case (branch_op)
      3'b000:  cond = zero_flag;
      3'b001:  cond = ~zero_flag;
      3'b100:  cond = sign_flag;
      3'b101:  cond = ~sign_flag;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    seq_pc    = pc_q + FOUR;
    br_taken  = branch_en & cond;
    in_run    = (state_q == RUN);
    target    = jalr ? (alu_result & ~ONE) : (pc_q + imm);
    taken_int = in_run & (jalr | jump | br_taken);
    next_pc   = taken_int ? target : seq_pc;
    trap      = taken_int & (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Resume is not gated by stall; halt entry is.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req && !stall) state_d = HALT;
      HALT:    if (resume)             state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      bad_addr_q  <= '0;
      misalign_q  <= 1'b0;
      retired_q   <= CNT_INIT;
      taken_cnt_q <= CNT_INIT;
    end else if (!in_run || stall) begin
      misalign_q <= 1'b0;
    end else if (trap) begin
      pc_q       <= TRAP_PC;
      bad_addr_q <= target;
      misalign_q <= 1'b1;
    end else begin
      pc_q       <= next_pc;
      misalign_q <= 1'b0;
      retired_q  <= retired_q + 32'd1;
      if (taken_int) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = seq_pc;
  assign taken         = taken_int;
  assign misalign_trap = misalign_q;
  assign bad_addr      = bad_addr_q;
  assign halted        = (state_q == HALT);
  assign retired_count = retired_q;
  assign taken_count   = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; a second instance with counters preset near wrap covers the overflow case.
module tb_pc_branch_unit;

  logic        clk, rst, stall, halt_req, resume, branch_en, jump, jalr, zero_flag, sign_flag;
  logic [2:0]  branch_op;
  logic [31:0] imm, alu_result;
  logic [31:0] pc, pc_plus4, bad_addr, retired_count, taken_count;
  logic        taken, misalign_trap, halted;
  logic [31:0] w_pc, w_pc_plus4, w_bad_addr, w_retired, w_taken_cnt;
  logic        w_taken, w_misalign, w_halted;

  int vectors = 0;
  int errors  = 0;

  pc_branch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_en(branch_en), .branch_op(branch_op), .jump(jump), .jalr(jalr),
    .imm(imm), .alu_result(alu_result), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .misalign_trap(misalign_trap),
    .bad_addr(bad_addr), .halted(halted), .retired_count(retired_count), .taken_count(taken_count)
  );

  pc_branch_unit #(.CNT_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_en(branch_en), .branch_op(branch_op), .jump(jump), .jalr(jalr),
    .imm(imm), .alu_result(alu_result), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .taken(w_taken), .misalign_trap(w_misalign),
    .bad_addr(w_bad_addr), .halted(w_halted), .retired_count(w_retired), .taken_count(w_taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt_req = 0; resume = 0; branch_en = 0; branch_op = 3'b000;
    jump = 0; jalr = 0; imm = 32'h0; alu_result = 32'h0; zero_flag = 0; sign_flag = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1; clear_inputs();
    #2;
    vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    vectors++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
    vectors++; if (bad_addr !== 32'h0) begin errors++; $display("FAIL rst_bad_addr: got %h want %h", bad_addr, 32'h0); end
    vectors++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b want 0", misalign_trap); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    vectors++; if (retired_count !== 32'h0 || taken_count !== 32'h0) begin errors++; $display("FAIL rst_counters: got %h/%h want 0/0", retired_count, taken_count); end
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'(4 * (i + 1));
      vectors++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc); end
    end
    vectors++; if (retired_count !== 32'd4) begin errors++; $display("FAIL seq_retired: got %0d want 4", retired_count); end
    vectors++; if (taken_count !== 32'd0) begin errors++; $display("FAIL seq_taken_cnt: got %0d want 0", taken_count); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) step();
    vectors++; if (pc !== 32'h20) begin errors++; $display("FAIL br_start_pc: got %h want %h", pc, 32'h20); end
    branch_en = 1; branch_op = 3'b000; imm = 32'h40; zero_flag = 1;
    #1;
    vectors++; if (taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", taken); end
    step();
    vectors++; if (pc !== 32'h60) begin errors++; $display("FAIL beq_pc: got %h want %h", pc, 32'h60); end
    vectors++; if (taken_count !== 32'd1) begin errors++; $display("FAIL beq_taken_cnt: got %0d want 1", taken_count); end
    branch_op = 3'b100; zero_flag = 0; sign_flag = 0;
    #1;
    vectors++; if (taken !== 1'b0) begin errors++; $display("FAIL blt_taken: got %b want 0", taken); end
    step();
    vectors++; if (pc !== 32'h64) begin errors++; $display("FAIL blt_pc: got %h want %h", pc, 32'h64); end
    branch_op = 3'b101; imm = 32'h1C;
    step();
    vectors++; if (pc !== 32'h80 || taken_count !== 32'd2) begin errors++; $display("FAIL bge_pc_cnt: got %h/%0d want %h/2", pc, taken_count, 32'h80); end
    branch_op = 3'b010; zero_flag = 1; sign_flag = 1;
    #1;
    vectors++; if (taken !== 1'b0) begin errors++; $display("FAIL badop_taken: got %b want 0", taken); end
    step();
    vectors++; if (pc !== 32'h84) begin errors++; $display("FAIL badop_pc: got %h want %h", pc, 32'h84); end
    vectors++; if (retired_count !== 32'd12) begin errors++; $display("FAIL br_retired: got %0d want 12", retired_count); end
    clear_inputs();
  endtask

  task automatic test_jalr();
    jalr = 1; jump = 1; imm = 32'h10; alu_result = 32'h1235;
    #1;
    vectors++; if (pc_plus4 !== 32'h88) begin errors++; $display("FAIL jalr_link: got %h want %h", pc_plus4, 32'h88); end
    vectors++; if (taken !== 1'b1) begin errors++; $display("FAIL jalr_taken: got %b want 1", taken); end
    step();
    vectors++; if (pc !== 32'h1234) begin errors++; $display("FAIL jalr_pc: got %h want %h", pc, 32'h1234); end
    vectors++; if (taken_count !== 32'd3) begin errors++; $display("FAIL jalr_taken_cnt: got %0d want 3", taken_count); end
    clear_inputs();
  endtask

  task automatic test_trap();
    rst = 1; #1; rst = 0;
    step(); step();
    vectors++; if (pc !== 32'h8) begin errors++; $display("FAIL trap_start_pc: got %h want %h", pc, 32'h8); end
    jump = 1; imm = 32'h6;
    step();
    vectors++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h want %h", pc, 32'h100); end
    vectors++; if (bad_addr !== 32'hE) begin errors++; $display("FAIL trap_bad_addr: got %h want %h", bad_addr, 32'hE); end
    vectors++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL trap_pulse: got %b want 1", misalign_trap); end
    vectors++; if (retired_count !== 32'd2 || taken_count !== 32'd0) begin errors++; $display("FAIL trap_counters: got %0d/%0d want 2/0", retired_count, taken_count); end
    clear_inputs();
    step();
    vectors++; if (misalign_trap !== 1'b0 || pc !== 32'h104) begin errors++; $display("FAIL trap_after: got %b/%h want 0/%h", misalign_trap, pc, 32'h104); end
    jump = 1; imm = 32'h2; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc !== 32'h104 || misalign_trap !== 1'b0 || retired_count !== 32'd3 || bad_addr !== 32'hE) begin
        errors++; $display("FAIL stall%0d: pc=%h trap=%b ret=%0d bad=%h want 104/0/3/e", i, pc, misalign_trap, retired_count, bad_addr);
      end
    end
    stall = 0;
    step();
    vectors++; if (pc !== 32'h100 || bad_addr !== 32'h106 || misalign_trap !== 1'b1) begin
      errors++; $display("FAIL stall_trap: pc=%h bad=%h trap=%b want 100/106/1", pc, bad_addr, misalign_trap);
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    rst = 1; #1; rst = 0;
    for (int i = 0; i < 4; i++) step();
    vectors++; if (pc !== 32'h10) begin errors++; $display("FAIL halt_start_pc: got %h want %h", pc, 32'h10); end
    halt_req = 1;
    step();
    vectors++; if (pc !== 32'h14 || halted !== 1'b1 || retired_count !== 32'd5) begin
      errors++; $display("FAIL halt_enter: pc=%h halted=%b ret=%0d want 14/1/5", pc, halted, retired_count);
    end
    halt_req = 0; jump = 1; imm = 32'h40;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      #1;
      vectors++; if (taken !== 1'b0) begin errors++; $display("FAIL halt_taken%0d: got %b want 0", i, taken); end
      step();
      vectors++; if (pc !== 32'h14 || retired_count !== 32'd5 || taken_count !== 32'd0) begin
        errors++; $display("FAIL halt_hold%0d: pc=%h ret=%0d tk=%0d want 14/5/0", i, pc, retired_count, taken_count);
      end
    end
    jump = 0; resume = 1; stall = 1;
    step();
    vectors++; if (halted !== 1'b0 || pc !== 32'h14) begin errors++; $display("FAIL resume: halted=%b pc=%h want 0/14", halted, pc); end
    clear_inputs();
    step();
    vectors++; if (pc !== 32'h18 || retired_count !== 32'd6) begin errors++; $display("FAIL resume_pc: pc=%h ret=%0d want 18/6", pc, retired_count); end
    halt_req = 1; resume = 1;
    step();
    vectors++; if (halted !== 1'b1 || pc !== 32'h1C) begin errors++; $display("FAIL both_run: halted=%b pc=%h want 1/1c", halted, pc); end
    step();
    vectors++; if (halted !== 1'b0 || pc !== 32'h1C) begin errors++; $display("FAIL both_halt: halted=%b pc=%h want 0/1c", halted, pc); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst = 1;
    #1;
    vectors++; if (pc !== 32'h0 || retired_count !== 32'h0 || taken_count !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_rst: pc=%h ret=%0d tk=%0d halted=%b want 0/0/0/0", pc, retired_count, taken_count, halted);
    end
    vectors++; if (w_retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffffffff", w_retired); end
    #1;
    rst = 0;
  endtask

  task automatic test_wrap();
    jump = 1; imm = 32'h8;
    step();
    vectors++; if (pc !== 32'h8 || retired_count !== 32'd1 || taken_count !== 32'd1) begin
      errors++; $display("FAIL post_rst_edge: pc=%h ret=%0d tk=%0d want 8/1/1", pc, retired_count, taken_count);
    end
    vectors++; if (w_retired !== 32'h0 || w_taken_cnt !== 32'h0) begin
      errors++; $display("FAIL counter_wrap: ret=%h tk=%h want 0/0", w_retired, w_taken_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_trap();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
